// File: rtl/dcache_refill_ctrl_if.sv
// Bus bundle between the refill engine (master) and the cache/memory side (slave).
// Handshake: a miss transfers when miss_valid && miss_ready, a memory request when
// mem_req_valid && mem_req_ready; the driver holds every field stable until then.
interface dcache_refill_ctrl_if #(
    parameter int ADDR_W     = 32,
    parameter int INDEX_W    = 7,
    parameter int TAG_W      = 19,
    parameter int LINE_WORDS = 16
);
    logic                     miss_valid;
    logic [ADDR_W-1:0]        miss_addr;
    logic                     miss_ready;
    logic [INDEX_W-1:0]       vic_index;
    logic [1:0]               vic_way;
    logic                     vic_valid;
    logic                     vic_dirty;
    logic [TAG_W-1:0]         vic_tag;
    logic [32*LINE_WORDS-1:0] vic_data;
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic                     mem_req_write;
    logic [ADDR_W-1:0]        mem_req_addr;
    logic [31:0]              mem_wdata;
    logic                     mem_rvalid;
    logic [31:0]              mem_rdata;
    logic                     fill_valid;
    logic [INDEX_W-1:0]       fill_index;
    logic [1:0]               fill_way;
    logic [TAG_W-1:0]         fill_tag;
    logic [32*LINE_WORDS-1:0] fill_data;
    logic                     done_valid;
    logic [ADDR_W-1:0]        done_addr;
    logic                     busy;

    modport master (
        input  miss_valid, miss_addr, vic_valid, vic_dirty, vic_tag, vic_data,
               mem_req_ready, mem_rvalid, mem_rdata,
        output miss_ready, vic_index, vic_way, mem_req_valid, mem_req_write,
               mem_req_addr, mem_wdata, fill_valid, fill_index, fill_way, fill_tag,
               fill_data, done_valid, done_addr, busy
    );

    modport slave (
        output miss_valid, miss_addr, vic_valid, vic_dirty, vic_tag, vic_data,
               mem_req_ready, mem_rvalid, mem_rdata,
        input  miss_ready, vic_index, vic_way, mem_req_valid, mem_req_write,
               mem_req_addr, mem_wdata, fill_valid, fill_index, fill_way, fill_tag,
               fill_data, done_valid, done_addr, busy
    );
endinterface

// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss/refill engine: round-robin victim pick, optional dirty write-back
// (macro DCACHE_WRITEBACK_EN), 16-beat line fetch, one-cycle fill and done pulses.
module dcache_refill_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int INDEX_W    = 7,
    parameter int TAG_W      = 19,
    parameter int LINE_WORDS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dcache_refill_ctrl_if.master bus,
    output logic [2:0]           dbg_state_o
);
    localparam int OFF_W  = ADDR_W - INDEX_W - TAG_W;
    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int LINE_W = 32 * LINE_WORDS;
    localparam int SETS   = 1 << INDEX_W;
    localparam int LA_W   = ADDR_W - OFF_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        VICTIM  = 3'd1,
`ifdef DCACHE_WRITEBACK_EN
        WB      = 3'd2,
`endif
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        FILL    = 3'd5
    } state_e;

    state_e              state_q;
    logic [LA_W-1:0]     line_q;
    logic [ADDR_W-1:0]   miss_addr_q;
    logic [1:0]          way_q;
    logic [1:0]          rr_ptr_q [SETS];
    logic [LA_W-1:0]     last_line_q;
    logic                last_vld_q;
    logic [BEAT_W-1:0]   beat_q;
    logic                miss_ready_q, busy_q, req_valid_q, fill_valid_q, done_valid_q;
    logic [ADDR_W-1:0]   req_addr_q, done_addr_q;
    logic [31:0]         wdata_q;
    logic [LINE_W-1:0]   fill_data_q;
    logic [INDEX_W-1:0]  fill_index_q, vic_index_q;
    logic [1:0]          fill_way_q, vic_way_q;
    logic [TAG_W-1:0]    fill_tag_q;
`ifdef DCACHE_WRITEBACK_EN
    logic                req_write_q;
    logic [TAG_W-1:0]    vic_tag_q;
    logic [LINE_W-1:0]   vic_data_q;
`endif

    logic [INDEX_W-1:0]  miss_idx;
    logic [LA_W-1:0]     miss_line;
    logic [BEAT_W-1:0]   beat_nx;
    logic                last_beat;

    assign miss_idx  = bus.miss_addr[OFF_W+INDEX_W-1:OFF_W];
    assign miss_line = bus.miss_addr[ADDR_W-1:OFF_W];
    assign beat_nx   = beat_q + BEAT_W'(1);
    assign last_beat = (beat_q == BEAT_W'(LINE_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            line_q       <= '0;
            miss_addr_q  <= '0;
            way_q        <= '0;
            for (int i = 0; i < SETS; i++) rr_ptr_q[i] <= 2'd0;
            last_line_q  <= '0;
            last_vld_q   <= 1'b0;
            beat_q       <= '0;
            miss_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            fill_valid_q <= 1'b0;
            done_valid_q <= 1'b0;
            req_addr_q   <= '0;
            done_addr_q  <= '0;
            wdata_q      <= '0;
            fill_data_q  <= '0;
            fill_index_q <= '0;
            fill_way_q   <= '0;
            fill_tag_q   <= '0;
            vic_index_q  <= '0;
            vic_way_q    <= '0;
`ifdef DCACHE_WRITEBACK_EN
            req_write_q  <= 1'b0;
            vic_tag_q    <= '0;
            vic_data_q   <= '0;
`endif
        end else begin
            fill_valid_q <= 1'b0;
            done_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.miss_valid) begin
                        // A refill of the most recently filled line would install a duplicate way.
                        if (last_vld_q && (last_line_q == miss_line)) begin
                            done_valid_q <= 1'b1;
                            done_addr_q  <= bus.miss_addr;
                        end else begin
                            line_q       <= miss_line;
                            miss_addr_q  <= bus.miss_addr;
                            vic_index_q  <= miss_idx;
                            vic_way_q    <= rr_ptr_q[miss_idx];
                            way_q        <= rr_ptr_q[miss_idx];
                            miss_ready_q <= 1'b0;
                            busy_q       <= 1'b1;
                            state_q      <= VICTIM;
                        end
                    end
                end
                VICTIM: begin
`ifdef DCACHE_WRITEBACK_EN
                    if (bus.vic_valid && bus.vic_dirty) begin
                        vic_tag_q   <= bus.vic_tag;
                        vic_data_q  <= bus.vic_data;
                        beat_q      <= '0;
                        req_valid_q <= 1'b1;
                        req_write_q <= 1'b1;
                        req_addr_q  <= {bus.vic_tag, line_q[INDEX_W-1:0], BEAT_W'(0), 2'b00};
                        wdata_q     <= bus.vic_data[31:0];
                        state_q     <= WB;
                    end else
`endif
                    begin
                        req_valid_q <= 1'b1;
                        req_addr_q  <= {line_q, {OFF_W{1'b0}}};
                        state_q     <= RD_REQ;
                    end
                end
`ifdef DCACHE_WRITEBACK_EN
                WB: begin
                    if (bus.mem_req_ready) begin
                        if (last_beat) begin
                            beat_q      <= '0;
                            req_write_q <= 1'b0;
                            req_addr_q  <= {line_q, {OFF_W{1'b0}}};
                            state_q     <= RD_REQ;
                        end else begin
                            beat_q     <= beat_nx;
                            req_addr_q <= {vic_tag_q, line_q[INDEX_W-1:0], beat_nx, 2'b00};
                            wdata_q    <= vic_data_q[32*beat_nx +: 32];
                        end
                    end
                end
`endif
                RD_REQ: begin
                    if (bus.mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        beat_q      <= '0;
                        state_q     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (bus.mem_rvalid) begin
                        fill_data_q[32*beat_q +: 32] <= bus.mem_rdata;
                        beat_q <= beat_nx;
                        if (last_beat) begin
                            fill_valid_q <= 1'b1;
                            done_valid_q <= 1'b1;
                            done_addr_q  <= miss_addr_q;
                            fill_index_q <= line_q[INDEX_W-1:0];
                            fill_tag_q   <= line_q[LA_W-1:INDEX_W];
                            fill_way_q   <= way_q;
                            state_q      <= FILL;
                        end
                    end
                end
                FILL: begin
                    rr_ptr_q[fill_index_q] <= rr_ptr_q[fill_index_q] + 2'd1;
                    last_line_q  <= line_q;
                    last_vld_q   <= 1'b1;
                    miss_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    miss_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                    req_valid_q  <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign bus.miss_ready    = miss_ready_q;
    assign bus.busy          = busy_q;
    assign bus.vic_index     = vic_index_q;
    assign bus.vic_way       = vic_way_q;
    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_addr  = req_addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.fill_valid    = fill_valid_q;
    assign bus.fill_index    = fill_index_q;
    assign bus.fill_way      = fill_way_q;
    assign bus.fill_tag      = fill_tag_q;
    assign bus.fill_data     = fill_data_q;
    assign bus.done_valid    = done_valid_q;
    assign bus.done_addr     = done_addr_q;
    assign dbg_state_o       = state_q;

`ifdef DCACHE_WRITEBACK_EN
    assign bus.mem_req_write = req_write_q;
`else
    // Write-through build: victim state never needs to leave the cache.
    logic unused_vic;
    assign unused_vic        = ^{bus.vic_valid, bus.vic_dirty, bus.vic_tag, bus.vic_data};
    assign bus.mem_req_write = 1'b0;
`endif
endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Directed bench for dcache_refill_ctrl with a cycle-stepped memory responder.
// Writeback vectors are selected by DCACHE_WRITEBACK_EN to match the DUT build.
module tb_dcache_refill_ctrl;
  localparam int W = 65;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;

  dcache_refill_ctrl_if bus ();

  dcache_refill_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    rst               = 1'b1;
    bus.miss_valid    = 1'b0;
    bus.miss_addr     = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = '0;
    bus.vic_valid     = 1'b0;
    bus.vic_dirty     = 1'b0;
    bus.vic_tag       = '0;
    bus.vic_data      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // scoreboard
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] exp_line();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = 32'hA000_0000 + 32'(i);
    return r;
  endfunction

  // results of the last run_miss
  int           fill_cnt, done_cnt, req_cycles, fill_cyc, done_cyc;
  logic [1:0]   fill_way_obs, vic_way_obs;
  logic [6:0]   fill_idx_obs, vic_idx_obs;
  logic [18:0]  fill_tag_obs;
  logic [511:0] fill_data_obs;
  logic [31:0]  done_addr_obs;
  logic         miss_ready_c1, busy_c1;

  // driver: one miss, memory with optional request stall and read-beat gaps
  task automatic run_miss(input logic [31:0] addr, input int stall, input bit gaps,
                          input bit dirty, input logic [18:0] vtag);
    int stall_left, rd_pending, rbeat, post;
    bit gap_next, seen_done;
    logic [W-1:0] obs;
    fill_cnt = 0; done_cnt = 0; req_cycles = 0; fill_cyc = -1; done_cyc = -1;
    bus.vic_valid = 1'b1;
    bus.vic_dirty = dirty;
    bus.vic_tag   = vtag;
    for (int i = 0; i < 16; i++) bus.vic_data[32*i +: 32] = 32'hD000_0000 + 32'(i);
    @(negedge clk);
    chk("miss_ready_idle", 512'(bus.miss_ready), 512'(1'b1));
    bus.miss_valid    = 1'b1;
    bus.miss_addr     = addr;
    bus.mem_req_ready = 1'b1;
    stall_left = stall; rd_pending = 0; rbeat = 0; gap_next = 0; post = 0; seen_done = 0;
    for (int cyc = 1; cyc <= 200 && post < 3; cyc++) begin
      @(negedge clk);
      bus.miss_valid = 1'b0;
      if (cyc == 1) begin
        vic_idx_obs   = bus.vic_index;
        vic_way_obs   = bus.vic_way;
        miss_ready_c1 = bus.miss_ready;
        busy_c1       = bus.busy;
      end
      if (bus.fill_valid) begin
        fill_cnt++;
        fill_cyc      = cyc;
        fill_idx_obs  = bus.fill_index;
        fill_way_obs  = bus.fill_way;
        fill_tag_obs  = bus.fill_tag;
        fill_data_obs = bus.fill_data;
      end
      if (seen_done) post++;
      if (bus.done_valid) begin
        done_cnt++;
        done_cyc      = cyc;
        done_addr_obs = bus.done_addr;
        seen_done     = 1'b1;
      end
      if (rd_pending > 0 && !(gaps && gap_next)) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hA000_0000 + 32'(rbeat);
        rbeat++;
        rd_pending--;
        gap_next = gaps;
      end else begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom();
        gap_next = 1'b0;
      end
      if (bus.mem_req_valid) begin
        req_cycles++;
        obs = {bus.mem_req_write, bus.mem_req_addr, bus.mem_req_write ? bus.mem_wdata : 32'h0};
        if (exp_q.size() == 0) begin
          bus.mem_req_ready = 1'b1;
          chk("unexpected_req", 512'(obs), 512'(0));
        end else if (stall_left > 0) begin
          bus.mem_req_ready = 1'b0;
          stall_left--;
          chk("req_stable_stall", 512'(obs), 512'(exp_q[0]));
        end else begin
          bus.mem_req_ready = 1'b1;
          chk("mem_req", 512'(obs), 512'(exp_q.pop_front()));
          if (!obs[64]) rd_pending = 16;
        end
      end else begin
        bus.mem_req_ready = ($urandom_range(0, 1) == 1);
      end
    end
    chk("done_seen", 512'(seen_done), 512'(1'b1));
    bus.mem_rvalid = 1'b0;
    bus.vic_valid  = 1'b0;
    bus.vic_dirty  = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_miss_ready", 512'(bus.miss_ready), 512'(1'b1));
    chk("rst_busy", 512'(bus.busy), 512'(1'b0));
    chk("rst_valids", 512'({bus.fill_valid, bus.done_valid, bus.mem_req_valid, bus.mem_req_write}), 512'(4'b0));
    chk("rst_fill_data", 512'(bus.fill_data), 512'(0));
    chk("rst_done_addr", 512'(bus.done_addr), 512'(0));
    chk("rst_state", 512'(dbg_state), 512'(3'd0));

    // cold miss, zero-wait memory
    exp_q.push_back({1'b0, 32'h0001_2340, 32'h0});
    run_miss(32'h0001_2344, 0, 1'b0, 1'b0, 19'h0);
    chk("cold_vic_index", 512'(vic_idx_obs), 512'(7'h0D));
    chk("cold_vic_way", 512'(vic_way_obs), 512'(2'd0));
    chk("cold_busy_c1", 512'(busy_c1), 512'(1'b1));
    chk("cold_fill_cyc", 512'(fill_cyc), 512'(19));
    chk("cold_fill_cnt", 512'(fill_cnt), 512'(1));
    chk("cold_fill_index", 512'(fill_idx_obs), 512'(7'h0D));
    chk("cold_fill_tag", 512'(fill_tag_obs), 512'(19'h9));
    chk("cold_fill_way", 512'(fill_way_obs), 512'(2'd0));
    chk("cold_word0", 512'(fill_data_obs[31:0]), 512'(32'hA000_0000));
    chk("cold_word15", 512'(fill_data_obs[511:480]), 512'(32'hA000_000F));
    chk("cold_line", fill_data_obs, exp_line());
    chk("cold_done_cyc", 512'(done_cyc), 512'(19));
    chk("cold_done_addr", 512'(done_addr_obs), 512'(32'h0001_2344));
    chk("cold_req_cycles", 512'(req_cycles), 512'(1));

    // same-line shortcut
    run_miss(32'h0001_2378, 0, 1'b0, 1'b0, 19'h0);
    chk("short_done_cyc", 512'(done_cyc), 512'(1));
    chk("short_done_addr", 512'(done_addr_obs), 512'(32'h0001_2378));
    chk("short_miss_ready", 512'(miss_ready_c1), 512'(1'b1));
    chk("short_no_req", 512'(req_cycles), 512'(0));
    chk("short_no_fill", 512'(fill_cnt), 512'(0));
    chk("short_done_cnt", 512'(done_cnt), 512'(1));

    // round robin on set 0x0D, then an untouched set
    do_reset();
    for (int t = 1; t <= 5; t++) begin
      logic [31:0] a;
      logic [1:0]  w;
      a = 32'(t) * 32'h2000 + 32'h340;
      w = 2'((t - 1) % 4);
      exp_q.push_back({1'b0, a, 32'h0});
      run_miss(a, 0, 1'b0, 1'b0, 19'h0);
      chk("rr_fill_way", 512'(fill_way_obs), 512'(w));
      chk("rr_fill_tag", 512'(fill_tag_obs), 512'(19'(t)));
    end
    exp_q.push_back({1'b0, 32'h0000_2380, 32'h0});
    run_miss(32'h0000_2384, 0, 1'b0, 1'b0, 19'h0);
    chk("rr_other_set_way", 512'(fill_way_obs), 512'(2'd0));
    chk("rr_other_set_idx", 512'(fill_idx_obs), 512'(7'h0E));

    // backpressure: request stall plus gapped read beats
    do_reset();
    exp_q.push_back({1'b0, 32'h0004_5680, 32'h0});
    run_miss(32'h0004_56A8, 5, 1'b1, 1'b0, 19'h0);
    chk("bp_fill_cyc", 512'(fill_cyc), 512'(39));
    chk("bp_line", fill_data_obs, exp_line());
    chk("bp_done_addr", 512'(done_addr_obs), 512'(32'h0004_56A8));

    // dirty victim, tag 0x5, index 0x0D
    do_reset();
`ifdef DCACHE_WRITEBACK_EN
    for (int i = 0; i < 16; i++)
      exp_q.push_back({1'b1, 32'h0000_A340 + 32'(4 * i), 32'hD000_0000 + 32'(i)});
    exp_q.push_back({1'b0, 32'h0000_E340, 32'h0});
    run_miss(32'h0000_E348, 0, 1'b0, 1'b1, 19'h5);
    chk("wb_fill_cyc", 512'(fill_cyc), 512'(35));
    chk("wb_req_cycles", 512'(req_cycles), 512'(17));
`else
    exp_q.push_back({1'b0, 32'h0000_E340, 32'h0});
    run_miss(32'h0000_E348, 0, 1'b0, 1'b1, 19'h5);
    chk("wt_fill_cyc", 512'(fill_cyc), 512'(19));
    chk("wt_req_cycles", 512'(req_cycles), 512'(1));
`endif
    chk("dirty_fill_tag", 512'(fill_tag_obs), 512'(19'h7));
    chk("dirty_line", fill_data_obs, exp_line());
    chk("exp_q_drained", 512'(exp_q.size()), 512'(0));

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
